atm_controller: RTL

Parametrised ATM session controller, the next generation of the `State_Machine` ATM block. It sequences card insertion, PIN entry, menu selection, withdrawal and balance display. New over the previous block: a bounded PIN-retry count with card retention, an inactivity timeout, a held balance register that decrements on withdrawal, and rising-edge qualification of `enter`. It sits between the keypad/card-reader front end and the cash-dispenser and display drivers.

---
 rtl/atm_controller.sv | 86 ++++++++
 1 files changed

// File: rtl/atm_controller.sv
// atm_controller: ATM session sequencer with PIN retry limit, inactivity timeout and held balance.
module atm_controller #(
  parameter int PIN_W       = 14,
  parameter int AMT_W       = 32,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card,
  input  logic             enter,
  input  logic [AMT_W-1:0] code,
  input  logic [PIN_W-1:0] exp_pin,
  input  logic [AMT_W-1:0] funds,
  output logic [3:0]       msg,
  output logic             cash_trap,
  output logic             eject_card,
  output logic             retain_card,
  output logic [AMT_W-1:0] balance,
  output logic [AMT_W-1:0] dispense_amt
);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int TRW = $clog2(MAX_TRIES + 1);
  typedef enum logic [3:0] {
    IDLE = 4'd0, PIN = 4'd1, BADPIN = 4'd2, MENU = 4'd3, AMOUNT = 4'd4,
    NOFUNDS = 4'd5, DISPENSE = 4'd6, EJECT = 4'd7, SHOWBAL = 4'd8, RETAIN = 4'd9
  } state_t;
  state_t state, nxt;
  logic [TW-1:0] timer;
  logic [TRW-1:0] tries;
  logic enter_q, ent, timed, gone, tout, pin_ok, last_try;
  assign ent      = enter & ~enter_q;
  assign timed    = state inside {PIN, MENU, AMOUNT, SHOWBAL};
  assign gone     = ~card && (state inside {PIN, BADPIN, MENU, AMOUNT, NOFUNDS, SHOWBAL});
  assign tout     = timed && timer == TW'(TIMEOUT_CYC - 1);
  assign pin_ok   = code[PIN_W-1:0] == exp_pin;
  assign last_try = tries + 1'b1 == TRW'(MAX_TRIES);
  // The state encoding is the display code, so the outputs are pure decodes of the state register.
  assign msg         = state;
  assign cash_trap   = state == DISPENSE;
  assign eject_card  = state == EJECT;
  assign retain_card = state == RETAIN;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = card ? PIN : IDLE;
      PIN:      nxt = !ent ? PIN : pin_ok ? MENU : last_try ? RETAIN : BADPIN;
      BADPIN:   nxt = PIN;
      MENU:     nxt = !ent ? MENU : code == AMT_W'(1) ? AMOUNT : code == AMT_W'(2) ? SHOWBAL
                    : code == AMT_W'(3) ? EJECT : MENU;
      AMOUNT:   nxt = (!ent || code == '0) ? AMOUNT : code > balance ? NOFUNDS : DISPENSE;
      NOFUNDS:  nxt = MENU;
      DISPENSE: nxt = EJECT;
      SHOWBAL:  nxt = ent ? MENU : SHOWBAL;
      EJECT:    nxt = card ? EJECT : IDLE;
      RETAIN:   nxt = card ? RETAIN : IDLE;
      default:  nxt = IDLE;
    endcase
    if (gone) nxt = IDLE;
    else if (tout) nxt = EJECT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      tries        <= '0;
      enter_q      <= 1'b0;
      balance      <= '0;
      dispense_amt <= '0;
    end else begin
      enter_q <= enter;
      state   <= nxt;
      timer   <= (ent || nxt != state || !timed) ? '0 : timer + 1'b1;
      if (state == IDLE && card) begin
        balance <= funds;
        tries   <= '0;
      end
      if (state == PIN && nxt inside {MENU, RETAIN, BADPIN})
        tries <= pin_ok ? '0 : tries + 1'b1;
      if (state == AMOUNT && nxt == DISPENSE) begin
        balance      <= balance - code;
        dispense_amt <= code;
      end
    end
  end
endmodule
